leaf_router: RTL and testbench

LEAF_ROUTER -- requirements
Module: leaf_router

---
 rtl/leaf_router_if.sv | 31 +++
 rtl/leaf_router.sv | 172 +++++++++++++++++
 tb/tb_leaf_router.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_router_if.sv
// Bus bundle for leaf_router: four NI ports, the uplink pair and the sticky error flags.
// The router uses the slave view; a traffic source or bench uses the master view.
interface leaf_router_if #(
    parameter int DATA_W = 16
);
    logic [4*DATA_W-1:0] local_data_in;
    logic [3:0]          local_valid_in;
    logic [3:0]          local_ready_out;
    logic [4*DATA_W-1:0] local_data_out;
    logic [3:0]          local_valid_out;
    logic [DATA_W-1:0]   up_data_in;
    logic                up_valid_in;
    logic                up_ready_out;
    logic [DATA_W-1:0]   up_data_out;
    logic                up_valid_out;
    logic                up_ready_in;
    logic [4:0]          err_overflow;
    logic                err_route;

    modport slave (
        input  local_data_in, local_valid_in, up_data_in, up_valid_in, up_ready_in,
        output local_ready_out, local_data_out, local_valid_out, up_ready_out,
               up_data_out, up_valid_out, err_overflow, err_route
    );

    modport master (
        output local_data_in, local_valid_in, up_data_in, up_valid_in, up_ready_in,
        input  local_ready_out, local_data_out, local_valid_out, up_ready_out,
               up_data_out, up_valid_out, err_overflow, err_route
    );
endinterface

// File: rtl/leaf_router.sv
// Five-input / five-output leaf router: per-input FIFOs, header-based routing and an
// independent round-robin arbiter per output feeding registered outputs.
module leaf_router #(
    parameter int GROUP_ID   = 5,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    leaf_router_if.slave bus
);
    localparam int NI = 5;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    GRP      = 4'(GROUP_ID);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_RDY  = CW'(FIFO_DEPTH - 2);

    logic [DATA_W-1:0] mem_q [NI][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [NI][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q [NI];
    logic [AW-1:0]     wr_ptr_d [NI];
    logic [AW-1:0]     rd_ptr_q [NI];
    logic [AW-1:0]     rd_ptr_d [NI];
    logic [CW-1:0]     cnt_q [NI];
    logic [CW-1:0]     cnt_d [NI];
    logic [2:0]        rr_q [NI];
    logic [2:0]        rr_d [NI];
    logic [3:0]        lv_q, lv_d;
    logic [DATA_W-1:0] ld_q [4];
    logic [DATA_W-1:0] ld_d [4];
    logic              uv_q, uv_d;
    logic [DATA_W-1:0] ud_q, ud_d;
    logic [3:0]        ovf_q, ovf_d;
    logic              rerr_q, rerr_d;

    logic [DATA_W-1:0] head [NI];
    logic [DATA_W-1:0] wdata [NI];
    logic [NI-1:0]     req [NI];
    logic [NI-1:0]     drop, push, pop;
    logic [5:0]        hdr;
    logic [3:0]        pick;

    // Returns {found, input}; scanning downward lets the closest-to-pointer request win.
    function automatic logic [3:0] rr_pick(input logic [NI-1:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = NI - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NI;
            if (r[idx]) res = {1'b1, 3'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        lv_d     = '0;
        ld_d     = ld_q;
        uv_d     = uv_q;
        ud_d     = ud_q;
        ovf_d    = ovf_q;
        rerr_d   = rerr_q;
        drop     = '0;
        push     = '0;
        pop      = '0;
        hdr      = '0;
        pick     = '0;
        for (int j = 0; j < NI; j++) begin
            req[j]  = '0;
            wdata[j] = '0;
        end

        for (int j = 0; j < NI; j++) begin
            head[j] = mem_q[j][rd_ptr_q[j]];
            hdr     = head[j][DATA_W-1 -: 6];
            if (cnt_q[j] != '0) begin
                if (hdr == 6'd0)              drop[j] = 1'b1;
                else if (hdr[5:2] == GRP)     req[hdr[1:0]][j] = 1'b1;
                else if (j == NI - 1)         drop[j] = 1'b1;  // uplink flit would U-turn
                else                          req[NI-1][j] = 1'b1;
            end
        end

        for (int o = 0; o < 4; o++) begin
            pick = rr_pick(req[o], rr_q[o]);
            if (pick[3]) begin
                pop[pick[2:0]] = 1'b1;
                rr_d[o]        = (pick[2:0] == 3'(NI - 1)) ? 3'd0 : pick[2:0] + 3'd1;
                lv_d[o]        = 1'b1;
                ld_d[o]        = head[pick[2:0]];
            end
        end

        pick = rr_pick(req[NI-1], rr_q[NI-1]);
        if (uv_q && bus.up_ready_in) uv_d = 1'b0;
        if (pick[3] && (!uv_q || bus.up_ready_in)) begin
            pop[pick[2:0]] = 1'b1;
            rr_d[NI-1]     = (pick[2:0] == 3'(NI - 1)) ? 3'd0 : pick[2:0] + 3'd1;
            uv_d           = 1'b1;
            ud_d           = head[pick[2:0]];
        end

        pop    = pop | drop;
        rerr_d = rerr_q | (|drop);

        for (int j = 0; j < 4; j++) begin
            wdata[j] = bus.local_data_in[j*DATA_W +: DATA_W];
            push[j]  = bus.local_valid_in[j] && (cnt_q[j] != CNT_FULL);
            if (bus.local_valid_in[j] && (cnt_q[j] == CNT_FULL)) ovf_d[j] = 1'b1;
        end
        wdata[NI-1] = bus.up_data_in;
        push[NI-1]  = bus.up_valid_in && (cnt_q[NI-1] != CNT_FULL);

        for (int j = 0; j < NI; j++) begin
            if (push[j]) begin
                mem_d[j][wr_ptr_q[j]] = wdata[j];
                wr_ptr_d[j]           = wr_ptr_q[j] + AW'(1);
            end
            if (pop[j]) rd_ptr_d[j] = rd_ptr_q[j] + AW'(1);
            cnt_d[j] = cnt_q[j] + CW'(push[j]) - CW'(pop[j]);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NI; j++) begin
                wr_ptr_q[j] <= '0;
                rd_ptr_q[j] <= '0;
                cnt_q[j]    <= '0;
                rr_q[j]     <= '0;
            end
            for (int i = 0; i < 4; i++) ld_q[i] <= '0;
            lv_q   <= '0;
            uv_q   <= 1'b0;
            ud_q   <= '0;
            ovf_q  <= '0;
            rerr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            ld_q     <= ld_d;
            lv_q     <= lv_d;
            uv_q     <= uv_d;
            ud_q     <= ud_d;
            ovf_q    <= ovf_d;
            rerr_q   <= rerr_d;
        end
    end

    // Ready leaves room for the flit already in flight when the NI samples it.
    for (genvar i = 0; i < 4; i++) begin : g_port
        assign bus.local_ready_out[i]                  = (cnt_q[i] <= CNT_RDY);
        assign bus.local_data_out[i*DATA_W +: DATA_W] = ld_q[i];
    end
    assign bus.local_valid_out = lv_q;
    assign bus.up_ready_out    = (cnt_q[NI-1] != CNT_FULL);
    assign bus.up_valid_out    = uv_q;
    assign bus.up_data_out     = ud_q;
    assign bus.err_overflow    = {1'b0, ovf_q};
    assign bus.err_route       = rerr_q;
endmodule

// File: tb/tb_leaf_router.sv
// Self-checking bench for leaf_router: directed scenarios plus random traffic compared
// cycle by cycle against a queue-based reference model.
module tb_leaf_router;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int GID   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    leaf_router_if #(.DATA_W(DW)) ifc ();
    leaf_router #(.GROUP_ID(GID), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (ifc)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [DW-1:0] mq [5][$];
    int            m_ptr [5];
    logic [3:0]    m_lv;
    logic [DW-1:0] m_ld [4];
    logic          m_uv;
    logic [DW-1:0] m_ud;
    logic [3:0]    m_ovf;
    logic          m_rerr;

    // stimulus held for the next edge
    logic [3:0]    s_lv;
    logic [DW-1:0] s_ld [4];
    logic          s_uv;
    logic [DW-1:0] s_ud;
    logic          s_urdy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_flit();
        logic [DW-1:0] f = DW'($urandom);
        int r = $urandom_range(0, 9);
        if (r == 0)     f[DW-1 -: 6] = 6'd0;
        else if (r < 7) f[DW-1 -: 4] = 4'(GID);
        return f;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 5; j++) begin
            mq[j].delete();
            m_ptr[j] = 0;
        end
        for (int i = 0; i < 4; i++) m_ld[i] = '0;
        m_lv = '0; m_uv = 1'b0; m_ud = '0; m_ovf = '0; m_rerr = 1'b0;
    endtask

    // One clock edge of the router, expressed as queue operations.
    // tgt: -1 idle, -2 dropped, 0..3 local leaf, 4 uplink
    task automatic model_step();
        int tgt [5];
        int sz [5];
        bit popf [5];
        logic [DW-1:0] hd [5];
        logic [5:0] h;
        int w, c;
        bit avail;
        for (int j = 0; j < 5; j++) begin
            sz[j] = mq[j].size(); popf[j] = 0; tgt[j] = -1; hd[j] = '0;
            if (sz[j] > 0) begin
                hd[j] = mq[j][0];
                h = hd[j][DW-1 -: 6];
                if (h == 6'd0)               tgt[j] = -2;
                else if (h[5:2] == 4'(GID))  tgt[j] = int'(h[1:0]);
                else if (j == 4)             tgt[j] = -2;
                else                         tgt[j] = 4;
            end
        end
        m_lv  = '0;
        avail = !m_uv || s_urdy;
        for (int o = 0; o < 5; o++) begin
            w = -1;
            if (o < 4 || avail) begin
                for (int k = 0; k < 5; k++) begin
                    c = (m_ptr[o] + k) % 5;
                    if (w < 0 && tgt[c] == o) w = c;
                end
            end
            if (w >= 0) begin
                popf[w]  = 1;
                m_ptr[o] = (w + 1) % 5;
                if (o < 4) begin
                    m_lv[o] = 1'b1;
                    m_ld[o] = hd[w];
                end else begin
                    m_uv = 1'b1;
                    m_ud = hd[w];
                end
            end else if (o == 4 && s_urdy) begin
                m_uv = 1'b0;
            end
        end
        for (int j = 0; j < 5; j++) begin
            if (tgt[j] == -2) begin
                popf[j] = 1;
                m_rerr  = 1'b1;
            end
            if (popf[j]) void'(mq[j].pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            if (s_lv[i]) begin
                if (sz[i] == DEPTH) m_ovf[i] = 1'b1;
                else                mq[i].push_back(s_ld[i]);
            end
        end
        if (s_uv && sz[4] != DEPTH) mq[4].push_back(s_ud);
    endtask

    task automatic apply();
        ifc.local_valid_in = s_lv;
        for (int i = 0; i < 4; i++) ifc.local_data_in[i*DW +: DW] = s_ld[i];
        ifc.up_valid_in = s_uv;
        ifc.up_data_in  = s_ud;
        ifc.up_ready_in = s_urdy;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("lvalid%0d", i), ifc.local_valid_out[i], m_lv[i]);
            if (m_lv[i]) check_val($sformatf("ldata%0d", i), ifc.local_data_out[i*DW +: DW], m_ld[i]);
            check_val($sformatf("lready%0d", i), ifc.local_ready_out[i], mq[i].size() <= DEPTH - 2);
        end
        check_val("uvalid", ifc.up_valid_out, m_uv);
        if (m_uv) check_val("udata", ifc.up_data_out, m_ud);
        check_val("uready", ifc.up_ready_out, mq[4].size() != DEPTH);
        check_val("err_ovf", ifc.err_overflow, {1'b0, m_ovf});
        check_val("err_route", ifc.err_route, m_rerr);
    endtask

    task automatic tick();
        apply();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        s_lv = '0;
        s_uv = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_lvalid"}, ifc.local_valid_out, 0);
        check_val({tag, "_ldata"}, ifc.local_data_out, 0);
        check_val({tag, "_uvalid"}, ifc.up_valid_out, 0);
        check_val({tag, "_udata"}, ifc.up_data_out, 0);
        check_val({tag, "_lready"}, ifc.local_ready_out, 4'hF);
        check_val({tag, "_uready"}, ifc.up_ready_out, 1);
        check_val({tag, "_ovf"}, ifc.err_overflow, 0);
        check_val({tag, "_route"}, ifc.err_route, 0);
    endtask

    initial begin
        int src_q[$];
        int exp_src[6] = '{0, 1, 2, 0, 1, 2};
        int n_valid;
        bit seen, leaked;

        for (int i = 0; i < 4; i++) s_ld[i] = '0;
        s_lv = '0; s_uv = 1'b0; s_ud = '0; s_urdy = 1'b1;
        model_reset();
        apply();
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // uncontended latency: in at n, out at n+2 on leaf 3 only
        s_ld[0] = 16'h5C2A; s_lv = 4'b0001;
        tick();
        idle();
        check_val("lat_n1_lvalid", ifc.local_valid_out, 4'b0000);
        tick();
        check_val("lat_n2_lvalid", ifc.local_valid_out, 4'b1000);
        check_val("lat_n2_ldata", ifc.local_data_out[3*DW +: DW], 16'h5C2A);
        check_val("lat_n2_uvalid", ifc.up_valid_out, 0);
        tick();

        // three inputs contend for leaf 0, twice
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) s_ld[k] = 16'h5000 | DW'(k);
            s_lv = 4'b0111;
            tick();
            if (ifc.local_valid_out[0]) src_q.push_back(int'(ifc.local_data_out[3:0]));
        end
        idle();
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ifc.local_valid_out[0]) src_q.push_back(int'(ifc.local_data_out[3:0]));
        end
        check_val("rr_count", src_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check_val($sformatf("rr_src%0d", k), (k < src_q.size()) ? src_q[k] : -1, exp_src[k]);
        end

        // uplink U-turn and null header dropped, then a local-group flit delivered
        n_valid = 0; seen = 0;
        s_uv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_ud = (k == 0) ? 16'h6000 : (k == 1) ? 16'h0000 : 16'h5400;
            tick();
            n_valid += $countones(ifc.local_valid_out) + int'(ifc.up_valid_out);
        end
        idle();
        for (int c = 0; c < 4; c++) begin
            tick();
            n_valid += $countones(ifc.local_valid_out) + int'(ifc.up_valid_out);
            if (ifc.local_valid_out[1] && ifc.local_data_out[DW +: DW] == 16'h5400) seen = 1;
        end
        check_val("drop_err_route", ifc.err_route, 1);
        check_val("drop_valid_count", n_valid, 1);
        check_val("uplink_to_leaf1", seen, 1);

        // uplink stalled: port 2 streams 6 flits ignoring ready
        s_urdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_ld[2] = 16'h6010 + DW'(k); s_lv = 4'b0100;
            tick();
            check_val($sformatf("ovf_ready2_%0d", k), ifc.local_ready_out[2], k < 3);
        end
        idle();
        check_val("ovf_flag2", ifc.err_overflow, 5'b00100);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_val($sformatf("hold_uvalid%0d", c), ifc.up_valid_out, 1);
            check_val($sformatf("hold_udata%0d", c), ifc.up_data_out, 16'h6010);
        end
        s_urdy = 1'b1;
        tick();
        check_val("drain_udata", ifc.up_data_out, 16'h6011);
        repeat (6) tick();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                s_lv[i] = ($urandom_range(0, 2) != 0) &&
                          (mq[i].size() <= DEPTH - 2 || $urandom_range(0, 9) == 0);
                s_ld[i] = rand_flit();
            end
            s_uv   = 1'($urandom_range(0, 1));
            s_ud   = rand_flit();
            s_urdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        s_urdy = 1'b0;
        repeat (8) tick();

        // reset mid-operation with flits queued
        for (int k = 0; k < 3; k++) s_ld[k] = 16'h6100 + DW'(k);
        s_lv = 4'b0111;
        tick();
        idle();
        tick();
        #2 rst = 1'b1;
        model_reset();
        #1 check_zero_outputs("midrst");
        tick();
        tick();
        rst = 1'b0;
        check_zero_outputs("postrst");
        s_urdy = 1'b1;
        leaked = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if ((|ifc.local_valid_out) || ifc.up_valid_out) leaked = 1;
        end
        check_val("postrst_no_leak", leaked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
